// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the time-shared run detector
package seq_det_pkg;

  localparam int S0 = 0;

  function automatic int ctx_w(input int run_len);
    return $clog2(run_len + 1);
  endfunction

  // Generic saturating increment; callers size-cast the result to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter: first request at or above ptr, wrapping
module rr_arb #(
  parameter int NCH   = 4,
  parameter int IDX_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NCH-1:0]   o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int ch;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    ch    = 0;
    for (int off = 0; off < NCH; off++) begin
      ch = (int'(i_ptr) + off) % NCH;
      if (!o_any && i_req[ch]) begin
        o_gnt[ch] = 1'b1;
        o_idx     = IDX_W'(ch);
        o_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - one run-of-ones detector time-shared across NCH serial requesters
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     clr,
  input  logic [NCH-1:0]           req,
  input  logic [NCH-1:0]           din,
  output logic [NCH-1:0]           gnt,
  output logic [NCH-1:0]           match,
  output logic                     hit_vld,
  output logic [$clog2(NCH)-1:0]   hit_ch,
  input  logic [$clog2(NCH)-1:0]   rd_sel,
  output logic [CNT_W-1:0]         rd_cnt
);

  localparam int IDX_W = $clog2(NCH);
  localparam int CTX_W = ctx_w(RUN_LEN);
  localparam logic [CTX_W-1:0] CTX_S0  = CTX_W'(S0);
  localparam logic [CTX_W-1:0] CTX_RUN = CTX_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CTX_W-1:0] r_ctx [NCH];
  logic [CNT_W-1:0] r_cnt [NCH];
  logic [IDX_W-1:0] r_ptr;
  logic [NCH-1:0]   r_match;
  logic             r_hit_vld;
  logic [IDX_W-1:0] r_hit_ch;

  logic [NCH-1:0]   w_arb_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_xfer;
  logic             w_bit;
  logic [CTX_W-1:0] w_ctx_next;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_inc;

  rr_arb #(.NCH(NCH), .IDX_W(IDX_W)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // A grant always implies a request, so any grant while enabled is a transfer.
  assign gnt        = en ? w_arb_gnt : '0;
  assign w_xfer     = en & w_any;
  assign w_bit      = din[w_idx];
  assign w_ctx_next = w_bit ? CTX_W'(sat_inc(32'(r_ctx[w_idx]), 32'(RUN_LEN))) : CTX_S0;
  assign w_hit      = w_xfer & (w_ctx_next == CTX_RUN);
  assign w_cnt_inc  = CNT_W'(sat_inc(32'(r_cnt[w_idx]), 32'(CNT_MAX)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        r_ctx[i] <= CTX_S0;
        r_cnt[i] <= '0;
      end
      r_ptr     <= '0;
      r_match   <= '0;
      r_hit_vld <= 1'b0;
      r_hit_ch  <= '0;
    end else begin
      r_hit_vld <= w_hit;
      if (w_hit)
        r_hit_ch <= w_idx;
      if (w_xfer) begin
        r_ctx[w_idx]   <= w_ctx_next;
        r_match[w_idx] <= (w_ctx_next == CTX_RUN);
        r_ptr          <= (w_idx == IDX_W'(NCH - 1)) ? '0 : w_idx + IDX_W'(1);
      end
      // Clear wins over an increment landing on the same edge.
      if (clr) begin
        for (int i = 0; i < NCH; i++)
          r_cnt[i] <= '0;
      end else if (w_hit) begin
        r_cnt[w_idx] <= w_cnt_inc;
      end
    end
  end

  assign match   = r_match;
  assign hit_vld = r_hit_vld;
  assign hit_ch  = r_hit_ch;
  assign rd_cnt  = (32'(rd_sel) < 32'(NCH)) ? r_cnt[rd_sel] : '0;

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - directed bench with a per-cycle reference model for seq_det_sched
module tb_seq_det_sched;

  localparam int NCH     = 4;
  localparam int RUN_LEN = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic       clk = 1'b0;
  logic       rstn, en, clr;
  logic [3:0] req, din, gnt, match;
  logic       hit_vld;
  logic [1:0] hit_ch, rd_sel, rd_cnt;

  always #5 clk = ~clk;

  seq_det_sched #(.NCH(NCH), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .clr     (clr),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .match   (match),
    .hit_vld (hit_vld),
    .hit_ch  (hit_ch),
    .rd_sel  (rd_sel),
    .rd_cnt  (rd_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: length of the current run of ones per channel, served-next pointer, hit counts.
  int m_run [NCH];
  int m_cnt [NCH];
  int m_ptr = 0;
  int m_hit_ch = 0;
  bit m_hit_vld = 1'b0;
  int g;

  function automatic logic [3:0] model_gnt();
    logic [3:0] r;
    r = '0;
    if (en && req != 0) begin
      for (int off = 0; off < NCH; off++) begin
        if (r == 0 && req[(m_ptr + off) % NCH]) r[(m_ptr + off) % NCH] = 1'b1;
      end
    end
    return r;
  endfunction

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0;
      m_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    g = -1;
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        m_run[i] = 0;
        m_cnt[i] = 0;
      end
      m_ptr = 0; m_hit_ch = 0; m_hit_vld = 1'b0;
    end else begin
      m_hit_vld = 1'b0;
      if (en) begin
        for (int off = 0; off < NCH; off++)
          if (g < 0 && req[(m_ptr + off) % NCH]) g = (m_ptr + off) % NCH;
      end
      if (g >= 0) begin
        m_run[g] = din[g] ? m_run[g] + 1 : 0;
        m_ptr = (g + 1) % NCH;
        if (m_run[g] >= RUN_LEN) begin
          m_hit_vld = 1'b1;
          m_hit_ch = g;
        end
      end
      if (clr) begin
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      end else if (m_hit_vld) begin
        m_cnt[g] = (m_cnt[g] < CNT_MAX) ? m_cnt[g] + 1 : CNT_MAX;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] em;
    for (int i = 0; i < NCH; i++) em[i] = (m_run[i] >= RUN_LEN);
    chk("gnt", 32'(gnt), 32'(model_gnt()));
    chk("match", 32'(match), 32'(em));
    chk("hit_vld", 32'(hit_vld), 32'(m_hit_vld));
    chk("hit_ch", 32'(hit_ch), 32'(m_hit_ch));
    chk("rd_cnt", 32'(rd_cnt), 32'(m_cnt[rd_sel]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer1(input int ch, input logic b);
    req = '0; din = '0;
    req[ch] = 1'b1;
    din[ch] = b;
    cyc();
    req = '0;
  endtask

  int seq_a [5] = '{0, 1, 2, 3, 0};
  int seq_b [4] = '{1, 3, 1, 3};
  logic t2_bits [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic t2_exp  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int   t4_ch   [5] = '{0, 1, 0, 1, 0};
  logic t4_bit  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic t4_hit  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int n_hits;

  initial begin
    rstn = 1'b0; en = 1'b1; clr = 1'b0; req = 4'hF; din = 4'h0; rd_sel = 2'd0;
    // T1 reset with every channel requesting
    cyc(); cyc();
    chk("rst_match", 32'(match), 32'h0);
    chk("rst_hit_vld", 32'(hit_vld), 32'h0);
    chk("rst_hit_ch", 32'(hit_ch), 32'h0);
    chk("rst_rd_cnt", 32'(rd_cnt), 32'h0);
    rstn = 1'b1;
    #1;
    // T3 fairness, starting with the first grant after reset
    for (int k = 0; k < 5; k++) begin
      chk("rr_all", 32'(gnt), 32'(4'b0001 << seq_a[k]));
      cyc();
    end
    req = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_1010", 32'(gnt), 32'(4'b0001 << seq_b[k]));
      cyc();
    end
    req = '0;
    cyc();

    // T2 single channel run 1,1,1,0
    rd_sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      xfer1(2, t2_bits[k]);
      chk("t2_match2", 32'(match[2]), 32'(t2_exp[k]));
      chk("t2_hit", 32'(hit_vld), 32'(t2_exp[k]));
      if (t2_exp[k]) chk("t2_hit_ch", 32'(hit_ch), 32'd2);
    end
    chk("t2_cnt", 32'(rd_cnt), 32'd2);

    // T4 interleaved channels stay isolated
    rd_sel = 2'd1;
    for (int k = 0; k < 5; k++) begin
      xfer1(t4_ch[k], t4_bit[k]);
      chk("t4_hit", 32'(hit_vld), 32'(t4_hit[k]));
      if (t4_hit[k]) chk("t4_hit_ch", 32'(hit_ch), 32'd1);
    end
    chk("t4_match", 32'(match), 32'h2);
    chk("t4_cnt1", 32'(rd_cnt), 32'd1);

    // T5 saturation, clear priority, enable freeze
    rd_sel = 2'd3;
    n_hits = 0;
    for (int k = 0; k < 6; k++) begin
      xfer1(3, 1'b1);
      if (hit_vld) n_hits++;
    end
    chk("t5_nhits", 32'(n_hits), 32'd5);
    chk("t5_sat", 32'(rd_cnt), 32'd3);
    clr = 1'b1;
    xfer1(3, 1'b1);
    clr = 1'b0;
    chk("t5_clr_hit", 32'(hit_vld), 32'd1);
    chk("t5_clr_cnt", 32'(rd_cnt), 32'd0);
    en = 1'b0; req = 4'b1000; din = 4'b0000;
    #1;
    chk("t5_en0_gnt", 32'(gnt), 32'h0);
    cyc(); cyc(); cyc();
    chk("t5_en0_hit", 32'(hit_vld), 32'd0);
    chk("t5_en0_match", 32'(match[3]), 32'd1);
    en = 1'b1; din = 4'b1000;
    #1;
    chk("t5_resume_gnt", 32'(gnt), 32'h8);
    cyc();
    req = '0;
    chk("t5_resume_hit", 32'(hit_vld), 32'd1);
    chk("t5_resume_cnt", 32'(rd_cnt), 32'd1);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
